// File: rtl/vga_stream_gen_pkg.sv
// vga_stream_gen_pkg: stream word layout shared by the video pipeline blocks
// Word (26 bits, MSB first): rgb[25:23] (B=25, G=24, R=23), xc[22:13], yc[12:3], hs[2], vs[1], active[0]
package vga_stream_gen_pkg;
  localparam int stream_w = 26;
  typedef struct packed {
    logic [2:0] rgb;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       hs;
    logic       vs;
    logic       active;
  } rgb_str_t;
  function automatic rgb_str_t idle_word(input logic hs_act, input logic vs_act);
    idle_word = '{rgb: 3'b000, xc: 10'd0, yc: 10'd0, hs: ~hs_act, vs: ~vs_act, active: 1'b0};
  endfunction
endpackage

// File: rtl/vga_stream_gen_axis_counter.sv
// vga_axis_counter: one VGA timing axis, counter plus sync/visible decode
// Ports: clk, rst (sync, active-high), ce (enable), inc (advance request),
//        cnt (position), wrap (inc on last position), sync (sync level), vis (in visible region)
module vga_axis_counter #(
  parameter int   res = 640,
  parameter int   fp  = 16,
  parameter int   sw  = 96,
  parameter int   bp  = 48,
  parameter logic act = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       inc,
  output logic [9:0] cnt,
  output logic       wrap,
  output logic       sync,
  output logic       vis
);
  localparam int tot = res + fp + sw + bp;
  if (tot > 1024 || tot < 1) begin : g_range_err
    $error("vga_axis_counter: total %0d outside 1..1024", tot);
  end
  // Compare on 11 bits so a region boundary of exactly 1024 stays representable
  localparam logic [10:0] last    = 11'(tot - 1);
  localparam logic [10:0] sync_lo = 11'(res + fp);
  localparam logic [10:0] sync_hi = 11'(res + fp + sw);
  localparam logic [10:0] vis_end = 11'(res);
  logic [10:0] c11;
  assign c11  = {1'b0, cnt};
  assign wrap = inc && c11 == last;
  assign sync = (c11 >= sync_lo && c11 < sync_hi) ? act : ~act;
  assign vis  = c11 < vis_end;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (ce && inc) cnt <= wrap ? '0 : cnt + 10'd1;
endmodule

// File: rtl/vga_stream_gen.sv
// vga_stream_gen: VGA timing source emitting one 26-bit RGB stream word per enabled pixel
// Ports: px_clk, reset (sync, active-high, dominates ce), ce (pixel enable, holds all state when low),
//        RGBStr_o (stream word), frame_start (word at 0,0), line_start (word at xc=0)
module vga_stream_gen
  import vga_stream_gen_pkg::*;
#(
  parameter int         hres     = 640,
  parameter int         hfp      = 16,
  parameter int         hsw      = 96,
  parameter int         hbp      = 48,
  parameter int         vres     = 480,
  parameter int         vfp      = 10,
  parameter int         vsw      = 2,
  parameter int         vbp      = 33,
  parameter logic       hs_act   = 1'b0,
  parameter logic       vs_act   = 1'b0,
  parameter logic [2:0] bg_color = 3'b000
) (
  input  logic                px_clk,
  input  logic                reset,
  input  logic                ce,
  output logic [stream_w-1:0] RGBStr_o,
  output logic                frame_start,
  output logic                line_start
);
  logic [9:0] hc, vc;
  logic       h_wrap, v_wrap, hs, vs, h_vis, v_vis, active, at_origin;
  rgb_str_t   word;
  vga_axis_counter #(.res(hres), .fp(hfp), .sw(hsw), .bp(hbp), .act(hs_act)) u_h (
    .clk(px_clk), .rst(reset), .ce(ce), .inc(1'b1),
    .cnt(hc), .wrap(h_wrap), .sync(hs), .vis(h_vis)
  );
  vga_axis_counter #(.res(vres), .fp(vfp), .sw(vsw), .bp(vbp), .act(vs_act)) u_v (
    .clk(px_clk), .rst(reset), .ce(ce), .inc(h_wrap),
    .cnt(vc), .wrap(v_wrap), .sync(vs), .vis(v_vis)
  );
  assign active = h_vis && v_vis;
  assign word   = '{rgb: active ? bg_color : 3'b000, xc: hc, yc: vc, hs: hs, vs: vs, active: active};
  // at_origin tracks (hc,vc)==(0,0): set on reset and after the last pixel of the frame
  always_ff @(posedge px_clk)
    if (reset) begin
      RGBStr_o    <= idle_word(hs_act, vs_act);
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      at_origin   <= 1'b1;
    end else if (ce) begin
      RGBStr_o    <= word;
      frame_start <= at_origin;
      line_start  <= hc == 10'd0;
      at_origin   <= v_wrap;
    end
endmodule
